dmem_responder: RTL and testbench

Memory-side responder for the core's data-memory request/grant/rvalid interface; the slave that the core-side data interface talks to. It accepts one request at a time and applies optional grant wait states. Writes commit to an internal word array under byte enables. It returns read data, error and integrity on a one-cycle rvalid pulse. It sits between the core's data port and the on-chip data RAM in the simulation and FPGA top.

---
 rtl/dmem_pkg.sv | 39 +++
 rtl/dmem_intg_gen.sv | 15 +
 rtl/dmem_responder.sv | 148 ++++++++++++++
 tb/tb_dmem_responder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Integrity generation is used by dmem_responder only when DMEM_INTG_EN is defined.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // What the registered response carries; selects the rdata source.
  typedef enum logic [1:0] {
    RESP_WRITE = 2'd0,
    RESP_READ  = 2'd1,
    RESP_ERR   = 2'd2
  } dmem_resp_e;

  localparam int          DMEM_INTG_W    = 7;
  localparam logic [31:0] DMEM_ERR_RDATA = 32'hBABE_CAFE;

  // Bits of a 32-bit word that fold into integrity bit k (bit index mod 7 == k).
  function automatic logic [31:0] dmem_intg_mask(int k);
    logic [31:0] m;
    m = '0;
    for (int j = 0; j < 32; j++) begin
      if ((j % DMEM_INTG_W) == k) m[j] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [DMEM_INTG_W-1:0] dmem_intg(logic [31:0] d);
    logic [DMEM_INTG_W-1:0] r;
    for (int k = 0; k < DMEM_INTG_W; k++) begin
      r[k] = ^(d & dmem_intg_mask(k));
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_intg_gen.sv
// 7-bit interleaved-parity integrity for a 32-bit data word.
// Instantiated by dmem_responder only when DMEM_INTG_EN is defined.
module dmem_intg_gen
  import dmem_pkg::*;
(
  input  logic [31:0]            data,
  output logic [DMEM_INTG_W-1:0] intg
);

  for (genvar gi = 0; gi < DMEM_INTG_W; gi++) begin : g_bit
    localparam logic [31:0] MASK = dmem_intg_mask(gi);
    assign intg[gi] = ^(data & MASK);
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core data port: req/gnt/rvalid, optional grant wait states.
// Define DMEM_INTG_EN to generate read integrity and reject writes with bad write integrity.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
  parameter int unsigned GNT_DELAY   = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   data_req_i,
  input  logic                   data_we_i,
  input  logic [3:0]             data_be_i,
  input  logic [31:0]            data_addr_i,
  input  logic [31:0]            data_wdata_i,
  input  logic [DMEM_INTG_W-1:0] data_wdata_intg_i,
  output logic                   data_gnt_o,
  output logic                   data_rvalid_o,
  output logic [31:0]            data_rdata_o,
  output logic [DMEM_INTG_W-1:0] data_rdata_intg_o,
  output logic                   data_err_o
);

  localparam int          IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT    = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  CNT_LOAD = (GNT_DELAY > 0) ? 4'(GNT_DELAY - 1) : 4'd0;

  dmem_state_e      state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic             rvalid_reg;
  dmem_resp_e       resp_reg, resp_next;
  logic [31:0]      mem_rdata_reg;
  logic             gnt, accept, in_range, wintg_bad, wr_en, rd_en;
  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic             unused_bits;

  logic [31:0] mem [DEPTH_WORDS];

  assign in_range = ({1'b0, data_addr_i} >= {1'b0, BASE_ADDR}) && ({1'b0, data_addr_i} < LIMIT);
  assign offset   = data_addr_i - BASE_ADDR;
  assign idx      = offset[IDX_W+1:2];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    gnt        = 1'b0;
    unique case (state_reg)
      IDLE, RESP: begin
        if (data_req_i) begin
          if (GNT_DELAY == 0) begin
            gnt        = 1'b1;
            state_next = RESP;
          end else begin
            cnt_next   = CNT_LOAD;
            state_next = WAIT;
          end
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        // A request that drops before its grant is simply abandoned.
        if (!data_req_i) begin
          state_next = IDLE;
        end else if (cnt_reg == 4'd0) begin
          gnt        = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Gating with rst_ni keeps the unreset array from being written during reset.
  assign data_gnt_o = gnt & rst_ni;
  assign accept     = data_gnt_o & data_req_i;
  assign wr_en      = accept & data_we_i & in_range & ~wintg_bad;
  assign rd_en      = accept & ~data_we_i & in_range;

  always_comb begin
    resp_next = RESP_READ;
    if (!in_range || (data_we_i && wintg_bad)) resp_next = RESP_ERR;
    else if (data_we_i)                        resp_next = RESP_WRITE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      rvalid_reg <= 1'b0;
      resp_reg   <= RESP_WRITE;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      rvalid_reg <= accept;
      if (accept) resp_reg <= resp_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) mem[idx][b*8 +: 8] <= data_wdata_i[b*8 +: 8];
      end
    end
    if (rd_en) mem_rdata_reg <= mem[idx];
  end

  assign data_rvalid_o = rvalid_reg;
  assign data_err_o    = (resp_reg == RESP_ERR);

  always_comb begin
    data_rdata_o = 32'd0;
    unique case (resp_reg)
      RESP_READ:  data_rdata_o = mem_rdata_reg;
      RESP_ERR:   data_rdata_o = DMEM_ERR_RDATA;
      default:    data_rdata_o = 32'd0;
    endcase
  end

`ifdef DMEM_INTG_EN
  logic [DMEM_INTG_W-1:0] wdata_intg;
  logic [DMEM_INTG_W-1:0] rdata_intg;

  dmem_intg_gen u_wdata_intg (
    .data (data_wdata_i),
    .intg (wdata_intg)
  );

  dmem_intg_gen u_rdata_intg (
    .data (data_rdata_o),
    .intg (rdata_intg)
  );

  assign wintg_bad         = (wdata_intg != data_wdata_intg_i);
  assign data_rdata_intg_o = rdata_intg;
`else
  assign wintg_bad         = 1'b0;
  assign data_rdata_intg_o = '0;
`endif

  assign unused_bits = ^{offset[31:IDX_W+2], offset[1:0], data_wdata_intg_i};

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one zero-wait instance (A) and one three-wait instance (B).
// Build with DMEM_INTG_EN defined to also exercise integrity generation and checking.
module tb_dmem_responder;

  localparam int          DEPTH  = 64;
  localparam logic [31:0] BASE   = 32'h0010_0000;
  localparam logic [31:0] ERRVAL = 32'hBABE_CAFE;
`ifdef DMEM_INTG_EN
  localparam bit INTG_ON = 1'b1;
`else
  localparam bit INTG_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a_n, a_req, a_we, a_gnt, a_rvalid, a_err;
  logic [3:0]  a_be;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [6:0]  a_wintg, a_rintg;
  logic        rst_b_n, b_req, b_we, b_gnt, b_rvalid, b_err;
  logic [3:0]  b_be;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [6:0]  b_wintg, b_rintg;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .GNT_DELAY(0)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_a_n), .data_req_i(a_req), .data_we_i(a_we), .data_be_i(a_be),
    .data_addr_i(a_addr), .data_wdata_i(a_wdata), .data_wdata_intg_i(a_wintg),
    .data_gnt_o(a_gnt), .data_rvalid_o(a_rvalid), .data_rdata_o(a_rdata),
    .data_rdata_intg_o(a_rintg), .data_err_o(a_err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .GNT_DELAY(3)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_b_n), .data_req_i(b_req), .data_we_i(b_we), .data_be_i(b_be),
    .data_addr_i(b_addr), .data_wdata_i(b_wdata), .data_wdata_intg_i(b_wintg),
    .data_gnt_o(b_gnt), .data_rvalid_o(b_rvalid), .data_rdata_o(b_rdata),
    .data_rdata_intg_o(b_rintg), .data_err_o(b_err)
  );

  int checks = 0;
  int passes = 0;
  int txn    = 0;
  logic [31:0] mem_a [DEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Integrity: bit k is the parity of every data bit whose index leaves remainder k by 7.
  function automatic logic [6:0] true_intg(input logic [31:0] d);
    logic [6:0] r = '0;
    for (int j = 0; j < 32; j++) r[j % 7] = r[j % 7] ^ d[j];
    return r;
  endfunction

  function automatic logic [6:0] exp_rintg(input logic [31:0] d);
    return INTG_ON ? true_intg(d) : 7'd0;
  endfunction

  function automatic bit in_rng(input logic [31:0] addr);
    longint unsigned a = addr;
    return (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * DEPTH);
  endfunction

  // Reference model of one accepted transaction for instance A.
  task automatic model_a(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [6:0] wi,
                         output logic [31:0] er, output logic ee);
    int i;
    bit bad = INTG_ON && we && (wi != true_intg(wd));
    if (!in_rng(addr) || bad) begin
      er = ERRVAL;
      ee = 1'b1;
    end else begin
      i  = int'((longint'(addr) - longint'(BASE)) / 4);
      ee = 1'b0;
      if (we) begin
        for (int b = 0; b < 4; b++) if (be[b]) mem_a[i][b*8 +: 8] = wd[b*8 +: 8];
        er = 32'd0;
      end else begin
        er = mem_a[i];
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the response cycle with req low.
  task automatic a_xfer(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [6:0] wi);
    logic [31:0] er;
    logic        ee;
    a_req = 1'b1; a_we = we; a_be = be; a_addr = addr; a_wdata = wd; a_wintg = wi;
    #1;
    check("a_gnt", 32'(a_gnt), 32'd1);
    model_a(we, be, addr, wd, wi, er, ee);
    @(posedge clk); #1;
    a_req = 1'b0;
    check("a_rvalid", 32'(a_rvalid), 32'd1);
    check("a_rdata", a_rdata, er);
    check("a_err", 32'(a_err), 32'(ee));
    check("a_rintg", 32'(a_rintg), 32'(exp_rintg(er)));
    txn++;
    $display("txn %0d A we=%0b be=%h addr=%h wdata=%h -> rdata=%h err=%0b", txn, we, be, addr, wd,
             a_rdata, a_err);
  endtask

  task automatic a_idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      check("a_idle_rvalid", 32'(a_rvalid), 32'd0);
    end
  endtask

  // Instance B: raise req at posedge+1, count req cycles to gnt (bounded), then check response.
  task automatic b_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_cycles, input logic [31:0] er);
    int cyc = 0;
    b_req = 1'b1; b_we = we; b_be = 4'hF; b_addr = addr; b_wdata = wd; b_wintg = true_intg(wd);
    for (int c = 1; c <= 20; c++) begin
      #1;
      if (b_gnt) begin
        cyc = c;
        break;
      end
      @(posedge clk); #1;
    end
    check("b_gnt_cycle", 32'(cyc), 32'(exp_cycles));
    @(posedge clk); #1;
    b_req = 1'b0;
    check("b_rvalid", 32'(b_rvalid), 32'd1);
    check("b_rdata", b_rdata, er);
    check("b_err", 32'(b_err), 32'd0);
    txn++;
    $display("txn %0d B we=%0b addr=%h wdata=%h gnt_after=%0d -> rdata=%h", txn, we, addr, wd, cyc,
             b_rdata);
  endtask

  logic [31:0] w0, rnd_addr, rnd_data;
  logic [6:0]  rnd_intg;

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_be = 4'h0; a_addr = '0; a_wdata = '0; a_wintg = '0;
    b_req = 1'b0; b_we = 1'b0; b_be = 4'h0; b_addr = '0; b_wdata = '0; b_wintg = '0;
    repeat (2) @(posedge clk);
    #1;
    a_req = 1'b1; a_addr = BASE;
    #1;
    check("rst_gnt", 32'(a_gnt), 32'd0);
    check("rst_rvalid", 32'(a_rvalid), 32'd0);
    check("rst_rdata", a_rdata, 32'd0);
    check("rst_err", 32'(a_err), 32'd0);
    check("rst_rintg", 32'(a_rintg), 32'd0);
    check("rst_b_rvalid", 32'(b_rvalid), 32'd0);
    @(posedge clk); #1;
    a_req = 1'b0; rst_a_n = 1'b1; rst_b_n = 1'b1;
    a_idle(1);

    // Full write then read, then a single-byte merge.
    a_xfer(1'b1, 4'hF, 32'h0010_0010, 32'hDEAD_BEEF, true_intg(32'hDEAD_BEEF));
    a_xfer(1'b0, 4'hF, 32'h0010_0010, 32'h0, 7'h0);
    a_xfer(1'b1, 4'b0010, 32'h0010_0012, 32'h0000_5A00, true_intg(32'h0000_5A00));
    a_xfer(1'b0, 4'h0, 32'h0010_0013, 32'h0, 7'h0);
    check("partial_merge", a_rdata, 32'hDEAD_5AEF);
    a_xfer(1'b1, 4'h0, 32'h0010_0010, 32'hFFFF_FFFF, true_intg(32'hFFFF_FFFF));
    a_xfer(1'b0, 4'hF, 32'h0010_0010, 32'h0, 7'h0);
    a_idle(2);

    // Out-of-range accesses at both edges of the window; word 0 must not be aliased.
    w0 = 32'h1234_5678;
    a_xfer(1'b1, 4'hF, BASE, w0, true_intg(w0));
    a_xfer(1'b0, 4'hF, 32'h0000_0000, 32'h0, 7'h0);
    a_xfer(1'b1, 4'hF, BASE + 4 * DEPTH, 32'hAAAA_5555, true_intg(32'hAAAA_5555));
    a_xfer(1'b0, 4'hF, BASE - 4, 32'h0, 7'h0);
    a_xfer(1'b0, 4'hF, BASE + 4 * DEPTH - 4, 32'h0, 7'h0);
    a_xfer(1'b0, 4'hF, BASE, 32'h0, 7'h0);
    check("word0_kept", a_rdata, w0);

`ifdef DMEM_INTG_EN
    a_xfer(1'b1, 4'hF, BASE + 20, 32'hCAFE_F00D, true_intg(32'hCAFE_F00D) ^ 7'h04);
    check("intg_bad_err", 32'(a_err), 32'd1);
    a_xfer(1'b1, 4'hF, BASE + 24, 32'hFFFF_FFFF, true_intg(32'hFFFF_FFFF));
    a_xfer(1'b0, 4'hF, BASE + 24, 32'h0, 7'h0);
    check("intg_ones", 32'(a_rintg), 32'h0000_000F);
`endif

    // Back-to-back reads with req held throughout.
    for (int k = 0; k < 4; k++) a_xfer(1'b0, 4'hF, BASE + 32'(k * 4), 32'h0, 7'h0);
    a_idle(1);

    // Reset lands during the third of four pipelined reads.
    a_xfer(1'b0, 4'hF, BASE + 32'h10, 32'h0, 7'h0);
    a_xfer(1'b0, 4'hF, BASE, 32'h0, 7'h0);
    a_req = 1'b1; a_we = 1'b0; a_addr = BASE + 32'h10;
    #1;
    check("b2b_gnt3", 32'(a_gnt), 32'd1);
    @(posedge clk); #1;
    check("b2b_rvalid3", 32'(a_rvalid), 32'd1);
    a_addr = BASE;
    rst_a_n = 1'b0;
    #1;
    check("midrst_rvalid", 32'(a_rvalid), 32'd0);
    check("midrst_gnt", 32'(a_gnt), 32'd0);
    @(posedge clk); #1;
    a_req = 1'b0; rst_a_n = 1'b1;
    a_idle(3);
    a_xfer(1'b0, 4'hF, 32'h0010_0010, 32'h0, 7'h0);
    check("write_survives_rst", a_rdata, 32'hDEAD_5AEF);

    // Instance B: three grant wait states.
    b_xfer(1'b1, 32'h0010_0010, 32'hDEAD_BEEF, 4, 32'd0);
    b_xfer(1'b0, 32'h0010_0010, 32'h0, 4, 32'hDEAD_BEEF);
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h0010_0014; b_wdata = 32'h0BAD_F00D;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("b_abandon_gnt", 32'(b_gnt), 32'd0);
      @(posedge clk); #1;
    end
    b_req = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("b_abandon_gnt_idle", 32'(b_gnt), 32'd0);
      check("b_abandon_rvalid", 32'(b_rvalid), 32'd0);
      @(posedge clk); #1;
    end
    b_xfer(1'b0, 32'h0010_0010, 32'h0, 4, 32'hDEAD_BEEF);
    // Request held straight into the response cycle waits the full delay again.
    b_xfer(1'b0, 32'h0010_0010, 32'h0, 4, 32'hDEAD_BEEF);
    b_req = 1'b1;
    b_xfer(1'b0, 32'h0010_0010, 32'h0, 4, 32'hDEAD_BEEF);

    // Randomised traffic against the model, after a full prefill.
    for (int k = 0; k < DEPTH; k++) begin
      rnd_data = $urandom();
      a_xfer(1'b1, 4'hF, BASE + 32'(k * 4), rnd_data, true_intg(rnd_data));
    end
    for (int n = 0; n < 60; n++) begin
      rnd_data = $urandom();
      rnd_intg = true_intg(rnd_data);
      if ($urandom_range(0, 4) == 0) rnd_intg = rnd_intg ^ 7'(1 << $urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) rnd_addr = $urandom();
      else rnd_addr = BASE + 32'($urandom_range(0, DEPTH - 1) * 4) + 32'($urandom_range(0, 3));
      a_xfer(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rnd_addr, rnd_data, rnd_intg);
      if ($urandom_range(0, 2) == 0) a_idle(int'($urandom_range(1, 2)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
